// File: rtl/eq_band_scale_seq.sv
// Five-band scale-and-sum engine: one shared multiplier, five MAC cycles per sample.
// Optional EQ_SEQ_SAT_CNT_EN adds an 8-bit saturating count of clipped outputs.
module eq_band_scale_seq #(
  parameter int GAIN_SHIFT = 11
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        smpl_vld,
  input  logic [15:0] lp,
  input  logic [15:0] b1,
  input  logic [15:0] b2,
  input  logic [15:0] b3,
  input  logic [15:0] hp,
  input  logic [11:0] lp_gain,
  input  logic [11:0] b1_gain,
  input  logic [11:0] b2_gain,
  input  logic [11:0] b3_gain,
  input  logic [11:0] hp_gain,
  output logic [15:0] out,
  output logic        out_vld,
  output logic        sat,
  output logic        busy,
  output logic        overrun
`ifdef EQ_SEQ_SAT_CNT_EN
  ,
  output logic [7:0]  sat_cnt
`endif
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MAC  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]         state;
  logic [2:0]         idx;
  logic signed [18:0] acc;
  logic               term_sat;
  logic [15:0]        samp [5];
  logic [11:0]        gain [5];

  logic signed [28:0] prod;
  logic signed [28:0] shr;
  logic [15:0]        term;
  logic               term_clip;
  logic signed [18:0] acc_nxt;
  logic [15:0]        out_nxt;
  logic               fin_clip;

  // Head of the holding shift register is always the band being scaled.
  always_comb begin
    prod = $signed({{13{samp[0][15]}}, samp[0]})
         * $signed({17'd0, gain[0]});
    shr = prod >>> GAIN_SHIFT;
    term = shr[15:0];
    term_clip = 1'b0;
    if (shr > 29'sd32767) begin
      term = 16'h7FFF;
      term_clip = 1'b1;
    end else if (shr < -29'sd32768) begin
      term = 16'h8000;
      term_clip = 1'b1;
    end
    acc_nxt = acc + $signed({{3{term[15]}}, term});
    out_nxt = acc_nxt[15:0];
    fin_clip = 1'b0;
    if (acc_nxt > 19'sd32767) begin
      out_nxt = 16'h7FFF;
      fin_clip = 1'b1;
    end else if (acc_nxt < -19'sd32768) begin
      out_nxt = 16'h8000;
      fin_clip = 1'b1;
    end
  end

  assign busy = (state == MAC);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      idx      <= 3'd0;
      acc      <= '0;
      term_sat <= 1'b0;
      out      <= 16'h0000;
      out_vld  <= 1'b0;
      sat      <= 1'b0;
      overrun  <= 1'b0;
      for (int i = 0; i < 5; i++) begin
        samp[i] <= 16'h0000;
        gain[i] <= 12'h000;
      end
`ifdef EQ_SEQ_SAT_CNT_EN
      sat_cnt  <= 8'h00;
`endif
    end else begin
      out_vld <= 1'b0;
      overrun <= 1'b0;
      unique case (state)
        IDLE, DONE: begin
          if (smpl_vld) begin
            samp[0]  <= lp;
            samp[1]  <= b1;
            samp[2]  <= b2;
            samp[3]  <= b3;
            samp[4]  <= hp;
            gain[0]  <= lp_gain;
            gain[1]  <= b1_gain;
            gain[2]  <= b2_gain;
            gain[3]  <= b3_gain;
            gain[4]  <= hp_gain;
            acc      <= '0;
            term_sat <= 1'b0;
            idx      <= 3'd0;
            state    <= MAC;
          end else begin
            state <= IDLE;
          end
        end
        MAC: begin
          overrun  <= smpl_vld;
          acc      <= acc_nxt;
          term_sat <= term_sat | term_clip;
          for (int i = 0; i < 4; i++) begin
            samp[i] <= samp[i+1];
            gain[i] <= gain[i+1];
          end
          if (idx == 3'd4) begin
            state   <= DONE;
            out     <= out_nxt;
            sat     <= fin_clip | term_sat | term_clip;
            out_vld <= 1'b1;
`ifdef EQ_SEQ_SAT_CNT_EN
            if ((fin_clip | term_sat | term_clip) && sat_cnt != 8'hFF)
              sat_cnt <= sat_cnt + 8'd1;
`endif
          end else begin
            idx <= idx + 3'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_eq_band_scale_seq.sv
// Directed self-checking bench for eq_band_scale_seq.
// Expected values are hand-computed from the band/gain vectors.
module tb_eq_band_scale_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        smpl_vld;
  logic [15:0] lp, b1, b2, b3, hp;
  logic [11:0] lp_gain, b1_gain, b2_gain, b3_gain, hp_gain;
  logic [15:0] out;
  logic        out_vld, sat, busy, overrun;
`ifdef EQ_SEQ_SAT_CNT_EN
  logic [7:0]  sat_cnt;
  int          exp_cnt = 0;
`endif

  int n_checks = 0;
  int n_fail = 0;

  eq_band_scale_seq dut (
    .clk(clk), .rst(rst), .smpl_vld(smpl_vld),
    .lp(lp), .b1(b1), .b2(b2), .b3(b3), .hp(hp),
    .lp_gain(lp_gain), .b1_gain(b1_gain), .b2_gain(b2_gain),
    .b3_gain(b3_gain), .hp_gain(hp_gain),
    .out(out), .out_vld(out_vld), .sat(sat), .busy(busy),
    .overrun(overrun)
`ifdef EQ_SEQ_SAT_CNT_EN
    , .sat_cnt(sat_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_bands(
    input logic [15:0] s0, s1, s2, s3, s4,
    input logic [11:0] g0, g1, g2, g3, g4
  );
    lp = s0; b1 = s1; b2 = s2; b3 = s3; hp = s4;
    lp_gain = g0; b1_gain = g1; b2_gain = g2;
    b3_gain = g3; hp_gain = g4;
  endtask

  task automatic set_all(input logic [15:0] s, input logic [11:0] g);
    set_bands(s, s, s, s, s, g, g, g, g, g);
  endtask

  // Strobe one sample, then step until out_vld (bounded); lat = ticks after capture.
  task automatic run(output int lat);
    smpl_vld = 1'b1;
    tick();
    smpl_vld = 1'b0;
    lat = 0;
    while (!out_vld && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  task automatic test_reset();
    n_checks++;
    if ({out, out_vld, sat, busy, overrun} !== 20'h0) begin
      n_fail++;
      $display("FAIL reset: out=%h vld=%b sat=%b busy=%b ovr=%b, want all 0",
               out, out_vld, sat, busy, overrun);
    end
`ifdef EQ_SEQ_SAT_CNT_EN
    n_checks++;
    if (sat_cnt !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_sat_cnt: got %h want 00", sat_cnt);
    end
`endif
  endtask

  task automatic test_unity();
    set_all(16'h1000, 12'h800);
    smpl_vld = 1'b1;
    tick();
    smpl_vld = 1'b0;
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (busy !== 1'b1 || out_vld !== 1'b0) begin
        n_fail++;
        $display("FAIL unity_busy[%0d]: busy=%b vld=%b want 1 0", i, busy, out_vld);
      end
      tick();
    end
    n_checks++;
    if (out_vld !== 1'b1 || out !== 16'h5000 || sat !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL unity_out: vld=%b out=%h sat=%b busy=%b want 1 5000 0 0",
               out_vld, out, sat, busy);
    end
    tick();
    n_checks++;
    if (out_vld !== 1'b0 || out !== 16'h5000) begin
      n_fail++;
      $display("FAIL unity_hold: vld=%b out=%h want 0 5000", out_vld, out);
    end
  endtask

  task automatic check_result(input string name, input logic [15:0] e_out,
                              input logic e_sat);
    int lat;
    run(lat);
    n_checks++;
    if (lat !== 5 || out !== e_out || sat !== e_sat) begin
      n_fail++;
      $display("FAIL %s: lat=%0d out=%h sat=%b want lat=5 out=%h sat=%b",
               name, lat, out, sat, e_out, e_sat);
    end
`ifdef EQ_SEQ_SAT_CNT_EN
    if (e_sat) exp_cnt++;
    n_checks++;
    if (sat_cnt !== exp_cnt[7:0]) begin
      n_fail++;
      $display("FAIL %s_sat_cnt: got %0d want %0d", name, sat_cnt, exp_cnt);
    end
`endif
    tick();
  endtask

  task automatic test_pos_clip();
    set_all(16'h7FFF, 12'hFFF);
    check_result("pos_clip", 16'h7FFF, 1'b1);
  endtask

  task automatic test_neg_clip();
    set_all(16'h8000, 12'h800);
    check_result("neg_clip", 16'h8000, 1'b1);
  endtask

  task automatic test_floor();
    set_all(16'hFFFF, 12'h001);
    check_result("floor", 16'hFFFB, 1'b0);
  endtask

  // 256 - 128 + 0 + 0 + floor(-3/2048)=-1 -> 127
  task automatic test_mixed();
    set_bands(16'h0100, 16'hFF00, 16'h2000, 16'h0003, 16'hFFFD,
              12'h800, 12'h400, 12'h000, 12'h001, 12'h001);
    check_result("mixed", 16'h007F, 1'b0);
  endtask

  // LP term clips to 32767, B1 gives -32768: sum -1 but sat from term clip.
  task automatic test_term_sat();
    set_bands(16'h7FFF, 16'h8000, 16'h0000, 16'h0000, 16'h0000,
              12'hFFF, 12'h800, 12'h800, 12'h800, 12'h800);
    check_result("term_sat", 16'hFFFF, 1'b1);
  endtask

  task automatic test_overrun();
    int seen;
    set_all(16'h1000, 12'h800);
    smpl_vld = 1'b1;
    tick();
    smpl_vld = 1'b0;
    tick();
    set_all(16'h2000, 12'hFFF);
    smpl_vld = 1'b1;
    tick();
    smpl_vld = 1'b0;
    n_checks++;
    if (overrun !== 1'b1) begin
      n_fail++;
      $display("FAIL overrun_pulse: got %b want 1", overrun);
    end
    tick();
    n_checks++;
    if (overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL overrun_width: got %b want 0", overrun);
    end
    tick();
    tick();
    n_checks++;
    if (out_vld !== 1'b1 || out !== 16'h5000 || sat !== 1'b0) begin
      n_fail++;
      $display("FAIL overrun_out: vld=%b out=%h sat=%b want 1 5000 0",
               out_vld, out, sat);
    end
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (out_vld) seen++;
    end
    n_checks++;
    if (seen != 0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL overrun_dropped: extra out_vld=%0d busy=%b want 0 0", seen, busy);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    int ovr;
    set_all(16'h1000, 12'h800);
    run(lat);
    n_checks++;
    if (lat !== 5 || out !== 16'h5000) begin
      n_fail++;
      $display("FAIL b2b_first: lat=%0d out=%h want 5 5000", lat, out);
    end
    set_bands(16'h0100, 16'hFF00, 16'h2000, 16'h0003, 16'hFFFD,
              12'h800, 12'h400, 12'h000, 12'h001, 12'h001);
    smpl_vld = 1'b1;
    tick();
    smpl_vld = 1'b0;
    n_checks++;
    if (busy !== 1'b1 || out !== 16'h5000 || out_vld !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_accept: busy=%b out=%h vld=%b want 1 5000 0",
               busy, out, out_vld);
    end
    ovr = 0;
    lat = 0;
    while (!out_vld && lat < 20) begin
      tick();
      lat++;
      if (overrun) ovr++;
    end
    n_checks++;
    if (lat !== 5 || out !== 16'h007F || sat !== 1'b0 || ovr != 0) begin
      n_fail++;
      $display("FAIL b2b_second: lat=%0d out=%h sat=%b ovr=%0d want 5 007f 0 0",
               lat, out, sat, ovr);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    int seen;
    set_all(16'h1000, 12'h800);
    smpl_vld = 1'b1;
    tick();
    smpl_vld = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
`ifdef EQ_SEQ_SAT_CNT_EN
    exp_cnt = 0;
`endif
    n_checks++;
    if (busy !== 1'b0 || out !== 16'h0000 || sat !== 1'b0 || out_vld !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid: busy=%b out=%h sat=%b vld=%b want 0 0000 0 0",
               busy, out, sat, out_vld);
    end
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      if (out_vld) seen++;
      tick();
    end
    n_checks++;
    if (seen != 0) begin
      n_fail++;
      $display("FAIL rst_mid_novld: got %0d out_vld pulses want 0", seen);
    end
    set_all(16'hFFFF, 12'h001);
    check_result("rst_mid_after", 16'hFFFB, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    smpl_vld = 1'b0;
    set_all(16'h0000, 12'h000);
    tick();
    tick();
    test_reset();
    rst = 1'b0;
    tick();
    test_unity();
    test_pos_clip();
    test_neg_clip();
    test_floor();
    test_mixed();
    test_overrun();
    test_back_to_back();
    test_term_sat();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
